regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
Shares the single register-file write port between two requesters: req 0 is the pipeline writeback stage and req 1 is the multi-cycle unit. The block arbitrates round-robin and supports locked bursts for multi-register writes. It drives a registered write address, enable and data into the register file's 3-to-8 write decoder.

Parameters:
DATA_WIDTH, 16, width of write data
ADDR_WIDTH, 3, register address width (8 registers)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  synchronous active-high reset
rq0_valid  input  1  requester 0 has a write pending
rq0_lock  input  1  requester 0 holds the port for its next beat
rq0_addr  input  ADDR_WIDTH  requester 0 destination register
rq0_data  input  DATA_WIDTH  requester 0 write data
rq0_ready  output  1  requester 0 write accepted this cycle
rq1_valid  input  1  requester 1 has a write pending
rq1_lock  input  1  requester 1 holds the port for its next beat
rq1_addr  input  ADDR_WIDTH  requester 1 destination register
rq1_data  input  DATA_WIDTH  requester 1 write data
rq1_ready  output  1  requester 1 write accepted this cycle
rf_stall  input  1  register file cannot accept writes; no grants
wr_en  output  1  write enable to the register-file decoder (We)
wr_addr  output  ADDR_WIDTH  write address to the decoder (Addr)
wr_data  output  DATA_WIDTH  write data to the register array
wr_src  output  1  requester that produced the current write

Behaviour:
- Reset behaviour: all outputs 0; state IDLE; rr_last = 1, so req 0 wins the first tie.
- Handshake: a transfer on requester i happens when rqi_valid && rqi_ready. rqi_ready is combinational from state, valids and rf_stall. Requesters must hold addr, data and lock stable while valid && !ready.
- rf_stall = 1: both readies are 0, the state holds, and wr_en = 0 on the next cycle.
- Latency is 1 cycle. On an accepted transfer the block registers wr_en = 1, wr_addr, wr_data and wr_src = i at the next rising edge. A cycle with no transfer registers wr_en = 0. wr_addr and wr_data hold their last values while wr_en = 0.
- At most one ready is high per cycle.
- States: IDLE, LOCK0, LOCK1.
- IDLE:
  - Only one valid: that requester is granted.
  - Both valid: grant !rr_last.
  - On a transfer by i: rr_last <= i. If rqi_lock = 1, go to LOCKi; otherwise stay in IDLE.
- LOCKi:
  - Only requester i may be granted; the other requester's ready is 0 even if it is valid.
  - A transfer with rqi_lock = 0 returns to IDLE; a transfer with lock = 1 stays in LOCKi.
  - rqi_valid = 0 in LOCKi holds the state, with no timeout.
  - rr_last updates to i on each transfer.
- Fairness: after a locked burst ends, a waiting other requester wins the next tie. Worst-case wait without locks is 1 transfer.
- Reset asserted mid-burst: the block returns to IDLE and the next cycle has wr_en = 0. Any in-flight transfer in the reset cycle is discarded.
- No address range check; all 2^ADDR_WIDTH addresses are legal.

Optional Feature:
REGWR_ARB_R0_DROP_EN
- Defined: a transfer whose addr == 0 is still accepted (ready = 1, and the round-robin and lock state update normally). The registered wr_en is forced to 0, so register 0 is never written. wr_addr and wr_data still update.
- Undefined: writes to address 0 behave like every other address.

Test Plan:
- Reset priority: rst for 2 cycles, then rq0 and rq1 both valid with addr 3/5 and data 0x1111/0x2222. Required: cycle 1 rq0_ready = 1. The following cycle has wr_en = 1, wr_addr = 3, wr_data = 0x1111, wr_src = 0, and rq1_ready = 1. The cycle after that has wr_addr = 5, wr_data = 0x2222, wr_src = 1.
- Locked burst: rq1 sends 3 beats with lock = 1,1,0 to addr 1,2,3 while rq0 is continuously valid. Required: rq0_ready = 0 for all 3 beats. wr_addr sequence is 1,2,3 with wr_src = 1. rq0 is granted on the 4th cycle.
- Stall: both valid, rf_stall = 1 for 2 cycles. Required: both readies are 0 and wr_en = 0 for those cycles. Arbitration resumes on deassert with unchanged round-robin order.
- Mid-lock gap: rq0 is in LOCK0, then rq0_valid drops for 3 cycles while rq1 is valid. Required: rq1_ready = 0 throughout. rq0 resumes with lock = 0, then rq1 is granted the next cycle.
- Reset mid-burst: rst pulsed while in LOCK1. Required: the next cycle wr_en = 0, and after reset rq0 wins a tie.
- R0 drop (macro defined): rq0 writes addr 0, data 0xBEEF. Required: rq0_ready = 1 and wr_en stays 0. With the macro undefined: wr_en = 1, wr_addr = 0, wr_data = 0xBEEF.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// Round-robin arbiter with locked bursts sharing one register-file write port.
// Optional macro REGWR_ARB_R0_DROP_EN: accept writes to register 0 but suppress their write enable.
module regfile_wr_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  rq0_valid,
    input  logic                  rq0_lock,
    input  logic [ADDR_WIDTH-1:0] rq0_addr,
    input  logic [DATA_WIDTH-1:0] rq0_data,
    output logic                  rq0_ready,
    input  logic                  rq1_valid,
    input  logic                  rq1_lock,
    input  logic [ADDR_WIDTH-1:0] rq1_addr,
    input  logic [DATA_WIDTH-1:0] rq1_data,
    output logic                  rq1_ready,
    input  logic                  rf_stall,
    output logic                  wr_en,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [DATA_WIDTH-1:0] wr_data,
    output logic                  wr_src
);

    typedef enum logic [1:0] {IDLE, LOCK0, LOCK1} state_t;

    state_t                  state_q, state_d;
    logic                    rr_last_q, rr_last_d;
    logic                    wr_en_q, wr_en_d;
    logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
    logic [DATA_WIDTH-1:0]   wr_data_q, wr_data_d;
    logic                    wr_src_q, wr_src_d;
    logic                    xfer;
    logic                    drop;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            wr_src_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            wr_src_q  <= wr_src_d;
        end
    end

    always_comb begin
        rq0_ready = 1'b0;
        rq1_ready = 1'b0;
        if (!rf_stall) begin
            case (state_q)
                IDLE: begin
                    // On a tie the requester that did not go last wins.
                    if (rq0_valid && rq1_valid) begin
                        rq0_ready = rr_last_q;
                        rq1_ready = !rr_last_q;
                    end else begin
                        rq0_ready = rq0_valid;
                        rq1_ready = rq1_valid;
                    end
                end
                LOCK0:   rq0_ready = rq0_valid;
                LOCK1:   rq1_ready = rq1_valid;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_last_d = rr_last_q;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        wr_src_d  = wr_src_q;
        xfer      = 1'b0;
        if (rq0_valid && rq0_ready) begin
            xfer      = 1'b1;
            rr_last_d = 1'b0;
            state_d   = rq0_lock ? LOCK0 : IDLE;
            wr_addr_d = rq0_addr;
            wr_data_d = rq0_data;
            wr_src_d  = 1'b0;
        end else if (rq1_valid && rq1_ready) begin
            xfer      = 1'b1;
            rr_last_d = 1'b1;
            state_d   = rq1_lock ? LOCK1 : IDLE;
            wr_addr_d = rq1_addr;
            wr_data_d = rq1_data;
            wr_src_d  = 1'b1;
        end
`ifdef REGWR_ARB_R0_DROP_EN
        drop = (wr_addr_d == '0);
`else
        drop = 1'b0;
`endif
        wr_en_d = xfer && !drop;
    end

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign wr_src  = wr_src_q;

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: directed beats push expected writes, a monitor pops them.
module tb_regfile_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rq0_valid, rq0_lock, rq1_valid, rq1_lock, rf_stall;
    logic [2:0]  rq0_addr, rq1_addr;
    logic [15:0] rq0_data, rq1_data;
    logic        rq0_ready, rq1_ready;
    logic        wr_en, wr_src;
    logic [2:0]  wr_addr;
    logic [15:0] wr_data;

    typedef struct packed {
        logic [2:0]  a;
        logic [15:0] d;
        logic        s;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    regfile_wr_arbiter #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
        .clk(clk), .rst(rst),
        .rq0_valid(rq0_valid), .rq0_lock(rq0_lock), .rq0_addr(rq0_addr),
        .rq0_data(rq0_data), .rq0_ready(rq0_ready),
        .rq1_valid(rq1_valid), .rq1_lock(rq1_lock), .rq1_addr(rq1_addr),
        .rq1_data(rq1_data), .rq1_ready(rq1_ready),
        .rf_stall(rf_stall),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_src(wr_src)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // One beat: drive on the falling edge, check readies, queue the expected write.
    task automatic beat(input string name, input logic r,
                        input logic v0, input logic l0, input logic [2:0] a0, input logic [15:0] d0,
                        input logic v1, input logic l1, input logic [2:0] a1, input logic [15:0] d1,
                        input logic st, input logic e0, input logic e1);
        exp_t e;
        @(negedge clk);
        rst = r; rf_stall = st;
        rq0_valid = v0; rq0_lock = l0; rq0_addr = a0; rq0_data = d0;
        rq1_valid = v1; rq1_lock = l1; rq1_addr = a1; rq1_data = d1;
        #1;
        chk({name, ".rq0_ready"}, {31'd0, rq0_ready}, {31'd0, e0});
        chk({name, ".rq1_ready"}, {31'd0, rq1_ready}, {31'd0, e1});
        if (!r && e0) begin
`ifdef REGWR_ARB_R0_DROP_EN
            if (a0 != 3'd0) begin
                e.a = a0; e.d = d0; e.s = 1'b0; q.push_back(e);
            end
`else
            e.a = a0; e.d = d0; e.s = 1'b0; q.push_back(e);
`endif
        end else if (!r && e1) begin
            e.a = a1; e.d = d1; e.s = 1'b1; q.push_back(e);
        end
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (wr_en === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write actual addr=%0d data=%0h src=%0d required no write",
                         wr_addr, wr_data, wr_src);
            end else begin
                e = q.pop_front();
                if (wr_addr !== e.a || wr_data !== e.d || wr_src !== e.s) begin
                    errors++;
                    $display("FAIL write actual addr=%0d data=%0h src=%0d required addr=%0d data=%0h src=%0d",
                             wr_addr, wr_data, wr_src, e.a, e.d, e.s);
                end
            end
        end else if (wr_en !== 1'b0 && rst === 1'b0) begin
            checks++;
            errors++;
            $display("FAIL wr_en_unknown actual=%b required=0/1", wr_en);
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; rf_stall = 1'b0;
        rq0_valid = 0; rq0_lock = 0; rq0_addr = 0; rq0_data = 0;
        rq1_valid = 0; rq1_lock = 0; rq1_addr = 0; rq1_data = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset.wr_en",   {31'd0, wr_en},   32'd0);
        chk("reset.wr_addr", {29'd0, wr_addr}, 32'd0);
        chk("reset.wr_data", {16'd0, wr_data}, 32'd0);
        chk("reset.wr_src",  {31'd0, wr_src},  32'd0);

        // Reset priority: req 0 wins the first tie, then req 1.
        beat("prio1", 0, 1,0,3'd3,16'h1111, 1,0,3'd5,16'h2222, 0, 1,0);
        beat("prio2", 0, 1,0,3'd4,16'h3333, 1,0,3'd5,16'h2222, 0, 0,1);
        // Locked burst from req 1 while req 0 keeps asking.
        beat("pre",   0, 1,0,3'd4,16'h3333, 1,1,3'd1,16'hA001, 0, 1,0);
        beat("lk1",   0, 1,0,3'd6,16'h6666, 1,1,3'd1,16'hA001, 0, 0,1);
        beat("lk2",   0, 1,0,3'd6,16'h6666, 1,1,3'd2,16'hA002, 0, 0,1);
        beat("lk3",   0, 1,0,3'd6,16'h6666, 1,0,3'd3,16'hA003, 0, 0,1);
        beat("post",  0, 1,0,3'd6,16'h6666, 1,0,3'd7,16'h7777, 0, 1,0);
        // Stall holds state and round-robin order.
        beat("st1",   0, 1,0,3'd2,16'h2020, 1,0,3'd7,16'h7777, 1, 0,0);
        beat("st2",   0, 1,0,3'd2,16'h2020, 1,0,3'd7,16'h7777, 1, 0,0);
        beat("st3",   0, 1,0,3'd2,16'h2020, 1,0,3'd7,16'h7777, 0, 0,1);
        // Mid-lock gap on req 0.
        beat("gap0",  0, 1,1,3'd2,16'h2020, 1,0,3'd7,16'h7070, 0, 1,0);
        for (int i = 0; i < 3; i++)
            beat("gap",   0, 0,0,3'd0,16'h0000, 1,0,3'd7,16'h7070, 0, 0,0);
        beat("gapend",0, 1,0,3'd3,16'h3030, 1,0,3'd7,16'h7070, 0, 1,0);
        beat("gapnx", 0, 1,0,3'd4,16'h4040, 1,0,3'd7,16'h7070, 0, 0,1);
        // Reset in the middle of a req 1 burst discards the in-flight beat.
        beat("rb0",   0, 0,0,3'd0,16'h0000, 1,1,3'd1,16'h1A1A, 0, 0,1);
        beat("rbrst", 1, 1,0,3'd5,16'h5555, 1,1,3'd2,16'h2B2B, 0, 0,1);
        @(posedge clk);
        #2;
        chk("rst_mid.wr_en", {31'd0, wr_en}, 32'd0);
        beat("rbtie", 0, 1,0,3'd5,16'h5555, 1,0,3'd2,16'h2B2B, 0, 1,0);
        // Write to register 0.
        beat("r0",    0, 1,0,3'd0,16'hBEEF, 0,0,3'd0,16'h0000, 0, 1,0);
        beat("idle",  0, 0,0,3'd0,16'h0000, 0,0,3'd0,16'h0000, 0, 0,0);
        repeat (3) @(posedge clk);
        #2;
        chk("drain.pending", q.size(), 32'd0);
`ifndef REGWR_ARB_R0_DROP_EN
        chk("r0.wr_addr", {29'd0, wr_addr}, 32'd0);
        chk("r0.wr_data", {16'd0, wr_data}, 32'h0000BEEF);
`else
        chk("r0.wr_addr", {29'd0, wr_addr}, 32'd0);
        chk("r0.wr_data", {16'd0, wr_data}, 32'h0000BEEF);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
